cpu_csr_unit: RTL and testbench
===============================

// Module: cpu_csr_unit
// PURPOSE
//  Machine-mode CSR file for the RV32 core. Successor to the fixed four-register CSR file:
//   - parametrised hardware performance counters
//   - full 64-bit counter access through the high-half CSRs
//   - CSRRW/RS/RC semantics
//   - illegal-access flagging
//   - trap entry and MRET sequencing
//  Sits beside the writeback stage. Reads are combinational; all updates commit on the clock edge.
// PARAMETERS
//  NUM_HPM      4             number of mhpmcounter3.. instances (0..29)
//  HART_ID      0             value returned by mhartid (0xF14)
//  MTVEC_RESET  32'h0000_0000 mtvec reset value
// PORTS
//  clk          in   1   clock
//  rst_n        in   1   reset: synchronous, active-low
//  raddr        in   12  CSR read address
//  rdata        out  32  read data (combinational)
//  csr_op       in   2   00 none, 01 write, 10 set, 11 clear
//  waddr        in   12  CSR write address
//  wdata        in   32  write operand (rs1 / zimm)
//  illegal      out  1   current raddr/op access is illegal (combinational)
//  retire       in   1   one instruction retired this cycle (not a bubble)
//  hpm_event    in   max(NUM_HPM,1)  per-counter increment strobes
//  trap_valid   in   1   take trap this cycle
//  trap_pc      in   32  faulting/interrupted PC
//  trap_cause   in   32  mcause value; bit31 = interrupt
//  mret         in   1   MRET executing this cycle
//  trap_vector  out  32  redirect target on trap (combinational)
//  epc          out  32  current mepc, the MRET target
//  mie          out  1   mstatus.MIE
// BEHAVIOUR
//  Implemented CSRs:
//   - mstatus 300: MIE bit3, MPIE bit7, MPP[12:11] read 2'b11, other bits read 0
//   - misa 301: RO, 32'h4000_0100
//   - mscratch 340, mtvec 305, mepc 341, mcause 342
//   - mcycle/h B00/B80, minstret/h B02/B82, mhpmcounterN/h B03+i/B83+i
//   - mhartid F14: RO
//  Reset: mstatus bits, mepc, mcause, mscratch, all counters = 0; mtvec = MTVEC_RESET.
//  Read: rdata = CSR at raddr. Unimplemented address -> rdata 0.
//  illegal = (csr_op!=0) && (raddr unimplemented || (write-effect && addr[11:10]==2'b11)).
//   - write-effect: op 01 always; ops 10/11 only when wdata != 0.
//  Write value (when write-effect and not illegal):
//   - 01: wdata
//   - 10: old|wdata
//   - 11: old&~wdata
//   - illegal access writes nothing.
//  Field masks:
//   - mepc[1:0] forced 0
//   - mtvec[1] forced 0; mtvec[0] = MODE (1 = vectored)
//   - mstatus writes only MIE and MPIE
//  Counters: 64-bit, wrap 2^64-1 -> 0.
//   - mcycle +1 every cycle; minstret +1 when retire; hpm[i] +1 when hpm_event[i].
//   - Low-half write replaces bits [31:0] and keeps [63:32]; high-half write likewise.
//   - A counter written this cycle takes the written value only; no increment that cycle.
//   - Increment carries across 32 bits (no per-half wrap).
//  Trap (trap_valid=1):
//   - mepc <= {trap_pc[31:2],2'b00}; mcause <= trap_cause
//   - MPIE <= MIE; MIE <= 0
//  MRET (mret=1, trap_valid=0): MIE <= MPIE; MPIE <= 1.
//  Priority: trap_valid > mret > CSR op.
//   - A CSR write to mstatus/mepc/mcause in a trap/mret cycle is dropped.
//   - Writes to other CSRs still commit.
//   - Counters tick normally in these cycles.
//  trap_vector:
//   - {mtvec[31:2],2'b00} + 4*trap_cause[4:0] when mtvec[0]=1 and trap_cause[31]=1
//   - else {mtvec[31:2],2'b00}
//  Reset mid-operation: rst_n low overrides any trap/mret/op that cycle; all state = reset values.
//  hpm addresses at index >= NUM_HPM are unimplemented.
// TESTING
//  1. Reset, idle 10 cycles -> mcycle reads 10, minstret 0, mtvec = MTVEC_RESET, illegal 0.
//  2. Write mcycle=32'hFFFF_FFFF then idle 1 cycle -> mcycle 0, mcycleh 1 (carry);
//     write mcycleh alone -> low half unchanged.
//  3. csrrs mscratch 0xF0 after write 0x0F -> 0xFF; csrrc 0x0F -> 0xF0;
//     set on mhartid with wdata 0 -> illegal 0; wdata 1 -> illegal 1, no change.
//  4. MIE=1, trap_pc=0x103, cause=0x8000_0007, mtvec=0x1001 -> trap_vector 0x101C,
//     mepc 0x100, MIE 0, MPIE 1; then mret -> MIE 1, MPIE 1.
//  5. Same-cycle trap_valid + write mepc=0x55 -> mepc = trap value;
//     mret + write mscratch -> mscratch updated.
//  6. NUM_HPM=2: hpm_event=2'b10 for 5 cycles -> B04 reads 5, B03 reads 0;
//     access to B05 -> rdata 0, illegal 1.

Source files
------------

// File: rtl/cpu_csr_unit.sv
// Machine-mode CSR file: mstatus/misa/mscratch/mtvec/mepc/mcause/mhartid,
// 64-bit mcycle/minstret and NUM_HPM hardware performance counters,
// trap entry and MRET sequencing. Reads are combinational.
module cpu_csr_unit #(
    parameter int unsigned NUM_HPM     = 4,
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [11:0]                            raddr,
    output logic [31:0]                            rdata,
    input  logic [1:0]                             csr_op,
    input  logic [11:0]                            waddr,
    input  logic [31:0]                            wdata,
    output logic                                   illegal,
    input  logic                                   retire,
    input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event,
    input  logic                                   trap_valid,
    input  logic [31:0]                            trap_pc,
    input  logic [31:0]                            trap_cause,
    input  logic                                   mret,
    output logic [31:0]                            trap_vector,
    output logic [31:0]                            epc,
    output logic                                   mie
);

    localparam int unsigned HPM_W = (NUM_HPM > 0) ? NUM_HPM : 1;

    logic        mie_q, mpie_q;
    logic [31:0] mscratch_q, mtvec_q, mepc_q, mcause_q;
    logic [63:0] mcycle_q, minstret_q;
    logic [63:0] hpm_q [HPM_W];

    logic        write_effect, we;
    logic [31:0] wr_old, wval, tv_base;

    function automatic logic csr_hit(input logic [11:0] a);
        logic h;
        case (a)
            12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342,
            12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14: h = 1'b1;
            default: h = 1'b0;
        endcase
        for (int unsigned i = 0; i < NUM_HPM; i++) begin
            if (a == 12'hB03 + 12'(i) || a == 12'hB83 + 12'(i)) h = 1'b1;
        end
        return h;
    endfunction

    function automatic logic [31:0] csr_value(input logic [11:0] a);
        logic [31:0] v;
        case (a)
            12'h300: v = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
            12'h301: v = 32'h4000_0100;
            12'h305: v = mtvec_q;
            12'h340: v = mscratch_q;
            12'h341: v = mepc_q;
            12'h342: v = mcause_q;
            12'hB00: v = mcycle_q[31:0];
            12'hB80: v = mcycle_q[63:32];
            12'hB02: v = minstret_q[31:0];
            12'hB82: v = minstret_q[63:32];
            12'hF14: v = HART_ID;
            default: v = '0;
        endcase
        for (int unsigned i = 0; i < NUM_HPM; i++) begin
            if (a == 12'hB03 + 12'(i)) v = hpm_q[i][31:0];
            if (a == 12'hB83 + 12'(i)) v = hpm_q[i][63:32];
        end
        return v;
    endfunction

    // Read port, legality check and CSRRW/RS/RC write value.
    always_comb begin
        rdata        = csr_value(raddr);
        wr_old       = csr_value(waddr);
        write_effect = (csr_op == 2'b01) || (csr_op[1] && (wdata != '0));
        illegal      = (csr_op != 2'b00) &&
                       (!csr_hit(raddr) || (write_effect && raddr[11:10] == 2'b11));
        we           = write_effect && !illegal;
        case (csr_op)
            2'b10:   wval = wr_old | wdata;
            2'b11:   wval = wr_old & ~wdata;
            default: wval = wdata;
        endcase
    end

    // Trap redirect: vectored mode only applies to interrupts.
    always_comb begin
        tv_base     = mtvec_q & ~32'h3;
        trap_vector = tv_base;
        if (mtvec_q[0] && trap_cause[31])
            trap_vector = tv_base + {25'b0, trap_cause[4:0], 2'b00};
        epc = mepc_q;
        mie = mie_q;
    end

    // State update: trap beats mret beats CSR write for mstatus/mepc/mcause.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mscratch_q <= '0;
            mtvec_q    <= MTVEC_RESET;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
            for (int unsigned i = 0; i < HPM_W; i++) hpm_q[i] <= '0;
        end else begin
            if (we && waddr == 12'h340) mscratch_q <= wval;
            if (we && waddr == 12'h305) mtvec_q    <= wval & ~32'h2;

            if (trap_valid) begin
                mpie_q   <= mie_q;
                mie_q    <= 1'b0;
                mepc_q   <= trap_pc & ~32'h3;
                mcause_q <= trap_cause;
            end else if (mret) begin
                mie_q  <= mpie_q;
                mpie_q <= 1'b1;
            end else if (we) begin
                if (waddr == 12'h300) begin
                    mie_q  <= wval[3];
                    mpie_q <= wval[7];
                end
                if (waddr == 12'h341) mepc_q   <= wval & ~32'h3;
                if (waddr == 12'h342) mcause_q <= wval;
            end

            if (we && waddr == 12'hB00)      mcycle_q <= {mcycle_q[63:32], wval};
            else if (we && waddr == 12'hB80) mcycle_q <= {wval, mcycle_q[31:0]};
            else                             mcycle_q <= mcycle_q + 64'd1;

            if (we && waddr == 12'hB02)      minstret_q <= {minstret_q[63:32], wval};
            else if (we && waddr == 12'hB82) minstret_q <= {wval, minstret_q[31:0]};
            else if (retire)                 minstret_q <= minstret_q + 64'd1;

            for (int unsigned i = 0; i < NUM_HPM; i++) begin
                if (we && waddr == 12'hB03 + 12'(i))      hpm_q[i] <= {hpm_q[i][63:32], wval};
                else if (we && waddr == 12'hB83 + 12'(i)) hpm_q[i] <= {wval, hpm_q[i][31:0]};
                else if (hpm_event[i])                    hpm_q[i] <= hpm_q[i] + 64'd1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_csr_unit.sv
// Self-checking bench for cpu_csr_unit (NUM_HPM=2). Expected CSR read
// values are queued as stimulus is applied and compared when read back.
module tb_cpu_csr_unit;

    logic        clk;
    logic        rst_n;
    logic [11:0] raddr, waddr;
    logic [31:0] rdata, wdata;
    logic [1:0]  csr_op;
    logic        illegal, retire, trap_valid, mret, mie;
    logic [1:0]  hpm_event;
    logic [31:0] trap_pc, trap_cause, trap_vector, epc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [11:0] addr;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    cpu_csr_unit #(
        .NUM_HPM    (2),
        .HART_ID    (32'd5),
        .MTVEC_RESET(32'h0000_0100)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .raddr      (raddr),
        .rdata      (rdata),
        .csr_op     (csr_op),
        .waddr      (waddr),
        .wdata      (wdata),
        .illegal    (illegal),
        .retire     (retire),
        .hpm_event  (hpm_event),
        .trap_valid (trap_valid),
        .trap_pc    (trap_pc),
        .trap_cause (trap_cause),
        .mret       (mret),
        .trap_vector(trap_vector),
        .epc        (epc),
        .mie        (mie)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
        csr_op     = 2'b00;
        wdata      = '0;
        trap_valid = 1'b0;
        mret       = 1'b0;
        retire     = 1'b0;
        hpm_event  = '0;
    endtask

    task automatic expect_rd(input string n, input logic [11:0] a, input logic [31:0] v);
        exp_t e;
        e.name = n; e.addr = a; e.val = v;
        sb.push_back(e);
    endtask

    task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        csr_op = op; waddr = a; raddr = a; wdata = d;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        expect_rd("rst_mcycle", 12'hB00, 32'd0);
        expect_rd("rst_minstret", 12'hB02, 32'd0);
        expect_rd("rst_mtvec", 12'h305, 32'h0000_0100);
        expect_rd("rst_mstatus", 12'h300, 32'h0000_1800);
        expect_rd("rst_mhartid", 12'hF14, 32'd5);
        expect_rd("rst_misa", 12'h301, 32'h4000_0100);
        while (sb.size() > 0) begin
            e = sb.pop_front(); raddr = e.addr; #1; checks++;
            if (rdata !== e.val) begin errors++; $display("FAIL %s: rdata=%h expected=%h", e.name, rdata, e.val); end
        end
        checks++;
        if (mie !== 1'b0 || epc !== 32'd0) begin
            errors++; $display("FAIL rst_mie_epc: mie=%b epc=%h expected mie=0 epc=0", mie, epc);
        end
        repeat (10) step();
        expect_rd("idle10_mcycle", 12'hB00, 32'd10);
        expect_rd("idle10_mcycleh", 12'hB80, 32'd0);
        expect_rd("idle10_minstret", 12'hB02, 32'd0);
        expect_rd("idle10_mtvec", 12'h305, 32'h0000_0100);
        while (sb.size() > 0) begin
            e = sb.pop_front(); raddr = e.addr; #1; checks++;
            if (rdata !== e.val) begin errors++; $display("FAIL %s: rdata=%h expected=%h", e.name, rdata, e.val); end
        end
        checks++;
        if (illegal !== 1'b0) begin errors++; $display("FAIL idle_illegal: got=%b expected=0", illegal); end
    endtask

    task automatic test_counters();
        exp_t e;
        wr(2'b01, 12'hB00, 32'hFFFF_FFFF);
        #1; checks++;
        if (illegal !== 1'b0) begin errors++; $display("FAIL mcycle_wr_illegal: got=%b expected=0", illegal); end
        step();
        step();
        expect_rd("carry_mcycle", 12'hB00, 32'd0);
        expect_rd("carry_mcycleh", 12'hB80, 32'd1);
        while (sb.size() > 0) begin
            e = sb.pop_front(); raddr = e.addr; #1; checks++;
            if (rdata !== e.val) begin errors++; $display("FAIL %s: rdata=%h expected=%h", e.name, rdata, e.val); end
        end
        wr(2'b01, 12'hB80, 32'h0000_1234);
        step();
        expect_rd("hiwr_mcycleh", 12'hB80, 32'h0000_1234);
        expect_rd("hiwr_mcycle_low_kept", 12'hB00, 32'd0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); raddr = e.addr; #1; checks++;
            if (rdata !== e.val) begin errors++; $display("FAIL %s: rdata=%h expected=%h", e.name, rdata, e.val); end
        end
        wr(2'b01, 12'hB02, 32'hFFFF_FFFF); retire = 1'b1;
        step();
        wr(2'b01, 12'hB82, 32'hFFFF_FFFF); retire = 1'b1;
        step();
        expect_rd("wr_minstret", 12'hB02, 32'hFFFF_FFFF);
        expect_rd("wr_minstreth", 12'hB82, 32'hFFFF_FFFF);
        while (sb.size() > 0) begin
            e = sb.pop_front(); raddr = e.addr; #1; checks++;
            if (rdata !== e.val) begin errors++; $display("FAIL %s: rdata=%h expected=%h", e.name, rdata, e.val); end
        end
        retire = 1'b1;
        step();
        expect_rd("wrap_minstret", 12'hB02, 32'd0);
        expect_rd("wrap_minstreth", 12'hB82, 32'd0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); raddr = e.addr; #1; checks++;
            if (rdata !== e.val) begin errors++; $display("FAIL %s: rdata=%h expected=%h", e.name, rdata, e.val); end
        end
        repeat (3) begin retire = 1'b1; step(); end
        step();
        expect_rd("retire3_minstret", 12'hB02, 32'd3);
        while (sb.size() > 0) begin
            e = sb.pop_front(); raddr = e.addr; #1; checks++;
            if (rdata !== e.val) begin errors++; $display("FAIL %s: rdata=%h expected=%h", e.name, rdata, e.val); end
        end
    endtask

    task automatic test_set_clear();
        exp_t e;
        wr(2'b01, 12'h340, 32'h0000_000F); step();
        wr(2'b10, 12'h340, 32'h0000_00F0); step();
        expect_rd("csrrs_mscratch", 12'h340, 32'h0000_00FF);
        while (sb.size() > 0) begin
            e = sb.pop_front(); raddr = e.addr; #1; checks++;
            if (rdata !== e.val) begin errors++; $display("FAIL %s: rdata=%h expected=%h", e.name, rdata, e.val); end
        end
        wr(2'b11, 12'h340, 32'h0000_000F); step();
        expect_rd("csrrc_mscratch", 12'h340, 32'h0000_00F0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); raddr = e.addr; #1; checks++;
            if (rdata !== e.val) begin errors++; $display("FAIL %s: rdata=%h expected=%h", e.name, rdata, e.val); end
        end
        wr(2'b10, 12'hF14, 32'd0);
        #1; checks++;
        if (illegal !== 1'b0) begin errors++; $display("FAIL hartid_set0_illegal: got=%b expected=0", illegal); end
        wdata = 32'd1;
        #1; checks++;
        if (illegal !== 1'b1) begin errors++; $display("FAIL hartid_set1_illegal: got=%b expected=1", illegal); end
        step();
        wr(2'b01, 12'h305, 32'hFFFF_FFFF); step();
        wr(2'b01, 12'h341, 32'h0000_0057); step();
        wr(2'b01, 12'h300, 32'hFFFF_FFFF); step();
        expect_rd("hartid_unchanged", 12'hF14, 32'd5);
        expect_rd("mtvec_mask", 12'h305, 32'hFFFF_FFFD);
        expect_rd("mepc_mask", 12'h341, 32'h0000_0054);
        expect_rd("mstatus_mask", 12'h300, 32'h0000_1888);
        while (sb.size() > 0) begin
            e = sb.pop_front(); raddr = e.addr; #1; checks++;
            if (rdata !== e.val) begin errors++; $display("FAIL %s: rdata=%h expected=%h", e.name, rdata, e.val); end
        end
        wr(2'b01, 12'h300, 32'd0); step();
    endtask

    task automatic test_trap_mret();
        exp_t e;
        wr(2'b01, 12'h300, 32'h0000_0008); step();
        wr(2'b01, 12'h305, 32'h0000_1001); step();
        checks++;
        if (mie !== 1'b1) begin errors++; $display("FAIL pre_trap_mie: got=%b expected=1", mie); end
        trap_valid = 1'b1; trap_pc = 32'h0000_0103; trap_cause = 32'h0000_0007;
        #1; checks++;
        if (trap_vector !== 32'h0000_1000) begin
            errors++; $display("FAIL trap_vector_exc: got=%h expected=00001000", trap_vector);
        end
        trap_cause = 32'h8000_0007;
        #1; checks++;
        if (trap_vector !== 32'h0000_101C) begin
            errors++; $display("FAIL trap_vector_irq: got=%h expected=0000101c", trap_vector);
        end
        step();
        checks++;
        if (epc !== 32'h0000_0100 || mie !== 1'b0) begin
            errors++; $display("FAIL trap_entry: epc=%h mie=%b expected epc=00000100 mie=0", epc, mie);
        end
        expect_rd("trap_mstatus", 12'h300, 32'h0000_1880);
        expect_rd("trap_mcause", 12'h342, 32'h8000_0007);
        while (sb.size() > 0) begin
            e = sb.pop_front(); raddr = e.addr; #1; checks++;
            if (rdata !== e.val) begin errors++; $display("FAIL %s: rdata=%h expected=%h", e.name, rdata, e.val); end
        end
        mret = 1'b1; step();
        checks++;
        if (mie !== 1'b1) begin errors++; $display("FAIL mret_mie: got=%b expected=1", mie); end
        expect_rd("mret_mstatus", 12'h300, 32'h0000_1888);
        while (sb.size() > 0) begin
            e = sb.pop_front(); raddr = e.addr; #1; checks++;
            if (rdata !== e.val) begin errors++; $display("FAIL %s: rdata=%h expected=%h", e.name, rdata, e.val); end
        end
    endtask

    task automatic test_priority();
        exp_t e;
        trap_valid = 1'b1; trap_pc = 32'h0000_0204; trap_cause = 32'h0000_0002;
        wr(2'b01, 12'h341, 32'h0000_0055);
        step();
        checks++;
        if (epc !== 32'h0000_0204) begin errors++; $display("FAIL trap_vs_mepc_wr: epc=%h expected=00000204", epc); end
        expect_rd("trap_cause2", 12'h342, 32'h0000_0002);
        expect_rd("trap2_mstatus", 12'h300, 32'h0000_1880);
        while (sb.size() > 0) begin
            e = sb.pop_front(); raddr = e.addr; #1; checks++;
            if (rdata !== e.val) begin errors++; $display("FAIL %s: rdata=%h expected=%h", e.name, rdata, e.val); end
        end
        mret = 1'b1; wr(2'b01, 12'h340, 32'h0000_ABCD); step();
        mret = 1'b1; wr(2'b01, 12'h342, 32'h0000_0009); step();
        expect_rd("mret_mscratch_wr", 12'h340, 32'h0000_ABCD);
        expect_rd("mret_mcause_drop", 12'h342, 32'h0000_0002);
        expect_rd("mret2_mstatus", 12'h300, 32'h0000_1888);
        while (sb.size() > 0) begin
            e = sb.pop_front(); raddr = e.addr; #1; checks++;
            if (rdata !== e.val) begin errors++; $display("FAIL %s: rdata=%h expected=%h", e.name, rdata, e.val); end
        end
    endtask

    task automatic test_hpm();
        exp_t e;
        repeat (5) begin hpm_event = 2'b10; step(); end
        expect_rd("hpm1_count", 12'hB04, 32'd5);
        expect_rd("hpm0_count", 12'hB03, 32'd0);
        expect_rd("hpm1_high", 12'hB84, 32'd0);
        expect_rd("hpm2_unimpl", 12'hB05, 32'd0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); raddr = e.addr; #1; checks++;
            if (rdata !== e.val) begin errors++; $display("FAIL %s: rdata=%h expected=%h", e.name, rdata, e.val); end
        end
        raddr = 12'hB05; waddr = 12'hB05; csr_op = 2'b10; wdata = 32'd0;
        #1; checks++;
        if (illegal !== 1'b1) begin errors++; $display("FAIL hpm2_illegal: got=%b expected=1", illegal); end
        csr_op = 2'b00;
        #1; checks++;
        if (illegal !== 1'b0) begin errors++; $display("FAIL hpm2_noop_illegal: got=%b expected=0", illegal); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        rst_n = 1'b0; trap_valid = 1'b1; trap_pc = 32'h0000_0300; trap_cause = 32'h0000_0003;
        wr(2'b01, 12'h340, 32'h0000_0077); hpm_event = 2'b11;
        step();
        rst_n = 1'b1;
        checks++;
        if (epc !== 32'd0 || mie !== 1'b0) begin
            errors++; $display("FAIL rstmid_epc_mie: epc=%h mie=%b expected epc=0 mie=0", epc, mie);
        end
        expect_rd("rstmid_mscratch", 12'h340, 32'd0);
        expect_rd("rstmid_mtvec", 12'h305, 32'h0000_0100);
        expect_rd("rstmid_mcause", 12'h342, 32'd0);
        expect_rd("rstmid_hpm1", 12'hB04, 32'd0);
        expect_rd("rstmid_mcycle", 12'hB00, 32'd0);
        expect_rd("rstmid_mcycleh", 12'hB80, 32'd0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); raddr = e.addr; #1; checks++;
            if (rdata !== e.val) begin errors++; $display("FAIL %s: rdata=%h expected=%h", e.name, rdata, e.val); end
        end
    endtask

    initial begin
        rst_n = 1'b0; raddr = '0; waddr = '0; wdata = '0; csr_op = 2'b00;
        retire = 1'b0; hpm_event = '0; trap_valid = 1'b0; trap_pc = '0;
        trap_cause = '0; mret = 1'b0;
        test_reset();
        test_counters();
        test_set_clear();
        test_trap_mret();
        test_priority();
        test_hpm();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
